// File: rtl/lane_center_tracker.sv
// Streaming lane-centre tracker: 3-tap row gradient, merged peak table, then a pairwise
// search for the edge pair whose centre lies nearest the previous frame's centre.
module lane_center_tracker #(
  parameter  int ROW_PIXELS = 32,
  parameter  int PIX_W      = 8,
  parameter  int MAX_PEAKS  = 4,
  parameter  int MIN_SEP    = 2,
  parameter  int MIN_LANE_W = 4,
  localparam int POS_W      = $clog2(ROW_PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] threshold,
  input  logic [PIX_W-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] center,
  output logic [PIX_W-1:0] confidence,
  output logic             lane_found,
  output logic             peak_overflow,
  output logic             busy
);

  localparam int IW = $clog2(MAX_PEAKS);
  localparam int CW = $clog2(MAX_PEAKS + 1);
  localparam logic [POS_W-1:0] CENTER_RST = POS_W'((ROW_PIXELS - 2) / 2);
  localparam logic [POS_W-1:0] LAST_PIX   = POS_W'(ROW_PIXELS - 1);
  localparam logic [IW-1:0]    LAST_IDX   = IW'(MAX_PEAKS - 1);
  localparam logic [IW-1:0]    PEN_IDX    = IW'(MAX_PEAKS - 2);

  typedef enum logic [1:0] {IDLE, RECEIVE, SELECT, OUTPUT} state_t;
  state_t state;

  logic [PIX_W-1:0] thr, h1, h2;
  logic [POS_W-1:0] idx;
  logic [POS_W-1:0] pk_pos [MAX_PEAKS];
  logic [PIX_W-1:0] pk_val [MAX_PEAKS];
  logic [MAX_PEAKS-1:0] pk_vld;
  logic [CW-1:0]    pk_cnt;
  logic             ovf;
  logic [IW-1:0]    p1, p2;
  logic [POS_W:0]   best_diff;
  logic             found, sel_done;
  logic [POS_W-1:0] best_c, last_center;
  logic [PIX_W-1:0] best_v1, best_v2;

  logic [PIX_W:0]   g_raw, g_abs;
  logic [PIX_W-1:0] mag;
  logic [POS_W-1:0] gpos, last_pos, sep;
  logic [IW-1:0]    last_i;
  logic             hit, close, replace, append, drop;

  // Gradient of the incoming pixel against p[i-2] and the peak-table decision.
  always_comb begin
    g_raw    = {1'b0, rx_data} - {1'b0, h2};
    g_abs    = g_raw[PIX_W] ? (~g_raw + (PIX_W+1)'(1)) : g_raw;
    mag      = g_abs[PIX_W] ? '1 : g_abs[PIX_W-1:0];
    gpos     = idx - POS_W'(2);
    last_i   = IW'(pk_cnt - CW'(1));
    last_pos = pk_pos[last_i];
    sep      = gpos - last_pos;
    hit      = (state == RECEIVE) && rx_valid && (idx >= POS_W'(2)) && (mag > thr);
    close    = (pk_cnt != '0) && (sep < POS_W'(MIN_SEP));
    replace  = hit && close && (mag > pk_val[last_i]);
    append   = hit && !close && (pk_cnt < CW'(MAX_PEAKS));
    drop     = hit && !close && (pk_cnt >= CW'(MAX_PEAKS));
  end

  logic [POS_W-1:0] a_pos, b_pos, pair_c, pair_diff;
  logic             pair_ok, better;

  always_comb begin
    a_pos     = pk_pos[p1];
    b_pos     = pk_pos[p2];
    pair_ok   = pk_vld[p1] && pk_vld[p2] && (b_pos >= a_pos) &&
                ((b_pos - a_pos) >= POS_W'(MIN_LANE_W));
    pair_c    = POS_W'(({1'b0, a_pos} + {1'b0, b_pos}) >> 1);
    pair_diff = (pair_c >= last_center) ? (pair_c - last_center) : (last_center - pair_c);
    better    = pair_ok && ({1'b0, pair_diff} < best_diff);
  end

  // Peak payload needs no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (replace) begin
      pk_pos[last_i] <= gpos;
      pk_val[last_i] <= mag;
    end else if (append) begin
      pk_pos[IW'(pk_cnt)] <= gpos;
      pk_val[IW'(pk_cnt)] <= mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rx_ready      <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      center        <= CENTER_RST;
      confidence    <= '0;
      lane_found    <= 1'b0;
      peak_overflow <= 1'b0;
      last_center   <= CENTER_RST;
      thr           <= '0;
      idx           <= '0;
      h1            <= '0;
      h2            <= '0;
      pk_vld        <= '0;
      pk_cnt        <= '0;
      ovf           <= 1'b0;
      p1            <= '0;
      p2            <= '0;
      best_diff     <= '1;
      found         <= 1'b0;
      sel_done      <= 1'b0;
      best_c        <= '0;
      best_v1       <= '0;
      best_v2       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RECEIVE;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            thr      <= threshold;
            idx      <= '0;
            pk_vld   <= '0;
            pk_cnt   <= '0;
            ovf      <= 1'b0;
          end
        end
        RECEIVE: begin
          if (rx_valid) begin
            h1  <= rx_data;
            h2  <= h1;
            idx <= idx + POS_W'(1);
            if (append) begin
              pk_vld[IW'(pk_cnt)] <= 1'b1;
              pk_cnt              <= pk_cnt + CW'(1);
            end
            if (drop) ovf <= 1'b1;
            if (idx == LAST_PIX) begin
              state     <= SELECT;
              rx_ready  <= 1'b0;
              p1        <= '0;
              p2        <= IW'(1);
              best_diff <= '1;
              found     <= 1'b0;
              sel_done  <= 1'b0;
            end
          end
        end
        SELECT: begin
          // One extra cycle after the last pair folds the winner into the output registers.
          if (sel_done) begin
            state         <= OUTPUT;
            out_valid     <= 1'b1;
            center        <= found ? best_c : last_center;
            confidence    <= found ? PIX_W'(({1'b0, best_v1} + {1'b0, best_v2}) >> 1) : '0;
            lane_found    <= found;
            peak_overflow <= ovf;
          end else begin
            if (better) begin
              best_diff <= {1'b0, pair_diff};
              best_c    <= pair_c;
              best_v1   <= pk_val[p1];
              best_v2   <= pk_val[p2];
              found     <= 1'b1;
            end
            if (p1 == PEN_IDX && p2 == LAST_IDX) begin
              sel_done <= 1'b1;
            end else if (p2 == LAST_IDX) begin
              p1 <= p1 + IW'(1);
              p2 <= p1 + IW'(2);
            end else begin
              p2 <= p2 + IW'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            if (lane_found) last_center <= center;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
